prbs8_rx_checker: RTL and testbench
===================================

PRBS8_RX_CHECKER -- requirements
Module: prbs8_rx_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter LOCK_CNT, default 4: consecutive matches needed in SYNC to enter LOCKED.
REQ-003 Parameter LOSS_CNT, default 3: consecutive mismatches in LOCKED that force SEARCH.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  8  received byte stream.
REQ-007 din_vld  input  1  din valid this cycle; no backpressure.
REQ-008 clr  input  1  synchronous clear of statistics.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 err_pulse  output  1  one-cycle strobe per mismatched byte while LOCKED.
REQ-011 err_cnt  output  16  saturating count of mismatched bytes while LOCKED.
REQ-012 rx_cnt  output  16  saturating count of bytes checked while LOCKED.
REQ-013 first_err_vld  output  1  first_err_data holds a captured byte.
REQ-014 first_err_data  output  8  received value of first mismatch since reset/clr.

Function
REQ-015 Reference sequence SHALL be next(s) = {s[6:0], s[7]^s[5]^s[4]^s[3]}: period 255, 0x00 illegal.
REQ-016 A byte is sampled only on a clk edge with din_vld=1; with din_vld=0, state, counters and reference SHALL hold.
REQ-017 States: SEARCH, SYNC, LOCKED; reset state SEARCH.
REQ-018 SEARCH: nonzero valid byte -> seed ref=din, match count 0, go SYNC; 0x00 -> stay SEARCH.
REQ-019 SYNC: din==next(ref) -> ref=din, match count +1; reaching LOCK_CNT -> LOCKED.
REQ-020 SYNC mismatch -> reseed ref=din (if nonzero, else go SEARCH), match count 0, stay SYNC; no error counted.
REQ-021 LOCKED: expected=next(ref); ref SHALL always advance to expected, never to din, so a corrupted byte counts once.
REQ-022 LOCKED match: rx_cnt+1, miss count 0.
REQ-023 LOCKED mismatch: rx_cnt+1, err_cnt+1, err_pulse=1 next cycle, miss count +1.
REQ-024 LOCKED mismatch when miss count reaches LOSS_CNT -> SEARCH; that byte is still counted.
REQ-025 All outputs SHALL be registered: effects of a byte sampled at edge N are visible after edge N.
REQ-026 locked SHALL rise on the edge that samples the LOCK_CNT-th match and fall on the edge that samples the LOSS_CNT-th miss.
REQ-027 err_cnt and rx_cnt SHALL saturate at 0xFFFF and not wrap.
REQ-028 first_err_data/first_err_vld SHALL capture only when first_err_vld=0; later errors leave them unchanged.
REQ-029 clr=1 SHALL zero err_cnt, rx_cnt and first_err_vld, with priority over a same-cycle increment or capture.
REQ-030 clr SHALL NOT affect state, ref, match/miss counts or err_pulse.

Reset
REQ-031 While rst_n=0, all state SHALL be forced immediately, independent of clk: state=SEARCH, ref=0x00, match/miss counts 0, locked=0, err_pulse=0, err_cnt=0, rx_cnt=0, first_err_vld=0, first_err_data=0x00.
REQ-032 Reset asserted mid-stream SHALL discard lock. After release, the first valid nonzero byte SHALL seed per REQ-018.

Verification
REQ-033 Sync: after reset, valid 0x01,0x02,0x04,0x08,0x11 back-to-back -> locked=1 after the 0x11 edge; err_cnt=0, rx_cnt=0.
REQ-034 Single error: locked, send 0xFF in place of one expected byte, then resume the correct sequence -> one err_pulse; err_cnt=1; first_err_data=0xFF; locked stays 1.
REQ-035 Loss: locked, send three consecutive wrong bytes -> err_cnt=3; locked=0 after the third; a following valid sequence relocks after 5 bytes.
REQ-036 Gaps/zero: din_vld toggled 1/0 during a valid sequence -> identical result to back-to-back. 0x00 in SEARCH -> stays SEARCH, locked=0.
REQ-037 clr: clr=1 on the same edge as a LOCKED mismatch -> err_cnt=0, first_err_vld=0, err_pulse=1 next cycle, locked unchanged.
REQ-038 Saturation/reset: force 0xFFFF errors -> err_cnt holds 0xFFFF. Assert rst_n=0 between edges -> all outputs zero immediately.

Source files
------------

// File: rtl/prbs8_rx_checker_if.sv
// rtl/prbs8_rx_checker_if.sv - received byte stream bundle for the PRBS8 checker
// Signals:
//   din      8-bit received byte
//   din_vld  din is valid this cycle (no backpressure)
// Modports: master drives the stream, slave (the checker) samples it.
interface prbs8_rx_checker_if;
  logic [7:0] din;
  logic       din_vld;

  modport master (output din, output din_vld);
  modport slave  (input  din, input  din_vld);
endinterface

// File: rtl/prbs8_rx_checker.sv
// rtl/prbs8_rx_checker.sv - PRBS8 receive checker with lock FSM and error statistics
// Ports:
//   clk             sole clock, rising edge
//   rst_n           asynchronous active-low reset
//   s               received stream (din / din_vld), slave side
//   clr             synchronous clear of err_cnt, rx_cnt, first_err_vld
//   locked          high while in LOCKED
//   err_pulse       one-cycle strobe per mismatched byte while LOCKED
//   err_cnt         saturating mismatch count while LOCKED
//   rx_cnt          saturating checked-byte count while LOCKED
//   first_err_vld   first_err_data holds a captured byte
//   first_err_data  received value of the first mismatch since reset/clr
module prbs8_rx_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  prbs8_rx_checker_if.slave         s,
  input  logic                      clr,
  output logic                      locked,
  output logic                      err_pulse,
  output logic [15:0]               err_cnt,
  output logic [15:0]               rx_cnt,
  output logic                      first_err_vld,
  output logic [7:0]                first_err_data
);

  // Match/miss counters only ever hold 0 .. LIMIT-1; reaching the limit is a transition.
  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [7:0]    ref_q, ref_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic [7:0]    expected;
  logic          chk_hit;
  logic          err_hit;

  assign expected = {ref_q[6:0], ref_q[7] ^ ref_q[5] ^ ref_q[4] ^ ref_q[3]};

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    miss_d  = miss_q;
    chk_hit = 1'b0;
    err_hit = 1'b0;
    if (s.din_vld) begin
      unique case (state_q)
        SEARCH: begin
          if (s.din != 8'h00) begin
            ref_d   = s.din;
            match_d = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          match_d = '0;
          if (s.din == expected) begin
            ref_d = s.din;
            if (match_q == MATCH_LAST) begin
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else if (s.din != 8'h00) begin
            ref_d = s.din;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Free-run the reference so a single corrupted byte costs one error, not two.
          ref_d   = expected;
          chk_hit = 1'b1;
          if (s.din != expected) begin
            err_hit = 1'b1;
            if (miss_q == MISS_LAST) begin
              miss_d  = '0;
              state_d = SEARCH;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      ref_q     <= 8'h00;
      match_q   <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_pulse <= err_hit;
    end
  end

  // Statistics: clr wins over any same-cycle increment or capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= 16'h0000;
      rx_cnt         <= 16'h0000;
      first_err_vld  <= 1'b0;
      first_err_data <= 8'h00;
    end else if (clr) begin
      err_cnt       <= 16'h0000;
      rx_cnt        <= 16'h0000;
      first_err_vld <= 1'b0;
    end else begin
      if (chk_hit && rx_cnt != 16'hFFFF)
        rx_cnt <= rx_cnt + 16'h0001;
      if (err_hit && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'h0001;
      if (err_hit && !first_err_vld) begin
        first_err_vld  <= 1'b1;
        first_err_data <= s.din;
      end
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs8_rx_checker.sv
// tb/tb_prbs8_rx_checker.sv - directed self-checking bench for prbs8_rx_checker
module tb_prbs8_rx_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        locked, err_pulse, first_err_vld;
  logic [15:0] err_cnt, rx_cnt;
  logic [7:0]  first_err_data;
  logic        s_locked, s_err_pulse, s_first_err_vld;
  logic [15:0] s_err_cnt, s_rx_cnt;
  logic [7:0]  s_first_err_data;

  int tests = 0;
  int fails = 0;

  prbs8_rx_checker_if s_if ();

  prbs8_rx_checker dut (
    .clk(clk), .rst_n(rst_n), .s(s_if.slave), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .rx_cnt(rx_cnt),
    .first_err_vld(first_err_vld), .first_err_data(first_err_data)
  );

  // Loss threshold above the error run so this copy stays locked while its counters saturate.
  prbs8_rx_checker #(.LOCK_CNT(4), .LOSS_CNT(70000)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s(s_if.slave), .clr(clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .rx_cnt(s_rx_cnt),
    .first_err_vld(s_first_err_vld), .first_err_data(s_first_err_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, let the rising edge sample it, then settle past the edge.
  task automatic step(input logic [7:0] b, input logic v, input logic c);
    s_if.din     = b;
    s_if.din_vld = v;
    clr          = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_if.din = 8'h00; s_if.din_vld = 1'b0;
    #3;
    chk("rst_locked", {15'd0, locked}, 16'h0);
    chk("rst_err_pulse", {15'd0, err_pulse}, 16'h0);
    chk("rst_err_cnt", err_cnt, 16'h0);
    chk("rst_rx_cnt", rx_cnt, 16'h0);
    chk("rst_fe_vld", {15'd0, first_err_vld}, 16'h0);
    chk("rst_fe_data", {8'd0, first_err_data}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x00 in SEARCH is ignored, then lock on 01 02 04 08 11.
    step(8'h00, 1, 0);  chk("zero_search", {15'd0, locked}, 16'h0);
    step(8'h01, 1, 0);
    step(8'h02, 1, 0);
    step(8'h04, 1, 0);
    step(8'h08, 1, 0);  chk("sync_pre_lock", {15'd0, locked}, 16'h0);
    step(8'h11, 1, 0);  chk("sync_locked", {15'd0, locked}, 16'h1);
    chk("sync_err_cnt", err_cnt, 16'h0);
    chk("sync_rx_cnt", rx_cnt, 16'h0);

    // Single corrupted byte in place of 0x47.
    step(8'h23, 1, 0);  chk("lock_rx1", rx_cnt, 16'h1);
    step(8'hFF, 1, 0);
    chk("single_err_pulse", {15'd0, err_pulse}, 16'h1);
    chk("single_err_cnt", err_cnt, 16'h1);
    chk("single_fe_vld", {15'd0, first_err_vld}, 16'h1);
    chk("single_fe_data", {8'd0, first_err_data}, 16'h00FF);
    step(8'h8E, 1, 0);
    chk("resume_err_pulse", {15'd0, err_pulse}, 16'h0);
    chk("resume_err_cnt", err_cnt, 16'h1);
    chk("resume_locked", {15'd0, locked}, 16'h1);
    step(8'h1C, 1, 0);  chk("resume_rx", rx_cnt, 16'h4);

    // Gaps with garbage on din must hold everything.
    step(8'h38, 1, 0);
    step(8'h5A, 0, 0);  chk("gap_rx_hold", rx_cnt, 16'h5);
    step(8'h71, 1, 0);
    step(8'h00, 0, 0);
    step(8'hE2, 1, 0);
    chk("gap_rx", rx_cnt, 16'h7);
    chk("gap_err_cnt", err_cnt, 16'h1);

    // clr on the same edge as a LOCKED mismatch (expected 0xC4).
    step(8'h55, 1, 1);
    chk("clr_err_cnt", err_cnt, 16'h0);
    chk("clr_rx_cnt", rx_cnt, 16'h0);
    chk("clr_fe_vld", {15'd0, first_err_vld}, 16'h0);
    chk("clr_err_pulse", {15'd0, err_pulse}, 16'h1);
    chk("clr_locked", {15'd0, locked}, 16'h1);
    step(8'h89, 1, 0);  chk("post_clr_rx", rx_cnt, 16'h1);

    // Three consecutive misses drop lock on the third.
    step(8'hAA, 1, 0);  chk("loss1_locked", {15'd0, locked}, 16'h1);
    step(8'hAA, 1, 0);  chk("loss2_locked", {15'd0, locked}, 16'h1);
    step(8'hAA, 1, 0);
    chk("loss3_locked", {15'd0, locked}, 16'h0);
    chk("loss_err_cnt", err_cnt, 16'h3);
    chk("loss_rx_cnt", rx_cnt, 16'h4);
    chk("loss_fe_data", {8'd0, first_err_data}, 16'h00AA);

    // Relock after 5 bytes.
    step(8'h01, 1, 0);
    step(8'h02, 1, 0);
    step(8'h04, 1, 0);
    step(8'h08, 1, 0);  chk("relock_pre", {15'd0, locked}, 16'h0);
    step(8'h11, 1, 0);  chk("relock", {15'd0, locked}, 16'h1);
    chk("relock_err_cnt", err_cnt, 16'h3);

    // Mid-stream reset between edges clears all outputs immediately.
    step(8'h00, 1, 0);  chk("pre_rst_pulse", {15'd0, err_pulse}, 16'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", {15'd0, locked}, 16'h0);
    chk("mid_rst_pulse", {15'd0, err_pulse}, 16'h0);
    chk("mid_rst_err_cnt", err_cnt, 16'h0);
    chk("mid_rst_rx_cnt", rx_cnt, 16'h0);
    chk("mid_rst_fe_vld", {15'd0, first_err_vld}, 16'h0);
    chk("mid_rst_fe_data", {8'd0, first_err_data}, 16'h0);
    #1;
    rst_n = 1'b1;

    // Reseed after reset; SYNC mismatch (0x01) restarts the match count.
    step(8'h23, 1, 0);
    step(8'h47, 1, 0);
    step(8'h01, 1, 0);
    step(8'h02, 1, 0);
    step(8'h04, 1, 0);
    step(8'h08, 1, 0);  chk("reseed_pre", {15'd0, locked}, 16'h0);
    step(8'h11, 1, 0);
    chk("reseed_locked", {15'd0, locked}, 16'h1);
    chk("reseed_rx", rx_cnt, 16'h0);
    chk("sat_copy_locked", {15'd0, s_locked}, 16'h1);

    // Saturation: 0x00 never matches in LOCKED.
    for (int i = 0; i < 65534; i++) step(8'h00, 1, 0);
    chk("sat_err_fffe", s_err_cnt, 16'hFFFE);
    step(8'h00, 1, 0);
    chk("sat_err_ffff", s_err_cnt, 16'hFFFF);
    step(8'h00, 1, 0);
    step(8'h00, 1, 0);
    chk("sat_err_hold", s_err_cnt, 16'hFFFF);
    chk("sat_rx_hold", s_rx_cnt, 16'hFFFF);
    chk("sat_locked", {15'd0, s_locked}, 16'h1);
    chk("main_lost", {15'd0, locked}, 16'h0);
    chk("main_err_cnt", err_cnt, 16'h3);

    rst_n = 1'b0;
    #1;
    chk("sat_rst_err_cnt", s_err_cnt, 16'h0);
    chk("sat_rst_rx_cnt", s_rx_cnt, 16'h0);
    chk("sat_rst_locked", {15'd0, s_locked}, 16'h0);
    chk("sat_rst_pulse", {15'd0, s_err_pulse}, 16'h0);
    chk("sat_rst_fe_vld", {15'd0, s_first_err_vld}, 16'h0);
    chk("sat_rst_fe_data", {8'd0, s_first_err_data}, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
